// File: rtl/obstacle_if.sv
// Bus between the dodge-game sequencer, the player controller and the sprite mixer.
// Obstacle slot i occupies bits [10i+9:10i] of obs_x and obs_y.
interface obstacle_if #(
    parameter int unsigned NUM_OBS = 4
);
    logic                    frame_tick;
    logic                    start;
    logic [9:0]              player_x;
    logic [9:0]              player_y;
    logic [NUM_OBS*10-1:0]   obs_x;
    logic [NUM_OBS*10-1:0]   obs_y;
    logic [NUM_OBS-1:0]      obs_active;
    logic                    game_over;
    logic [6:0]              score;
    logic [6:0]              max_score;

    modport master (
        output frame_tick, start, player_x, player_y,
        input  obs_x, obs_y, obs_active, game_over, score, max_score
    );

    modport slave (
        input  frame_tick, start, player_x, player_y,
        output obs_x, obs_y, obs_active, game_over, score, max_score
    );
endinterface

// File: rtl/obstacle_scheduler.sv
// Dodge-game sequencer: spawns, advances and retires falling obstacles once per
// frame, detects player collisions and keeps score, max score and difficulty.
module obstacle_scheduler #(
    parameter int unsigned NUM_OBS          = 4,
    parameter int unsigned SCREEN_H         = 480,
    parameter int unsigned OBS_SIZE         = 32,
    parameter int unsigned PLAYER_W         = 32,
    parameter int unsigned PLAYER_H         = 32,
    parameter int unsigned X_RANGE          = 608,
    parameter int unsigned SPAWN_DELAY_INIT = 60,
    parameter int unsigned SPAWN_DELAY_MIN  = 16,
    parameter int unsigned STEP_INIT        = 2,
    parameter logic [9:0]  LFSR_SEED        = 10'h2A5
) (
    input  logic        CLOCK_50,
    input  logic        reset,
    obstacle_if.slave   bus
);

    localparam int unsigned CW = 10;
    localparam int unsigned SW = 7;
    localparam int unsigned IW = (NUM_OBS > 1) ? $clog2(NUM_OBS) : 1;

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_PLAY   = 3'd1;
    localparam logic [2:0] S_UPDATE = 3'd2;
    localparam logic [2:0] S_SPAWN  = 3'd3;
    localparam logic [2:0] S_OVER   = 3'd4;

    logic [2:0]                  state_q, state_d;
    logic                        start_q;
    logic                        rise_q;
    logic [CW-1:0]               lfsr_q, lfsr_d;
    logic [NUM_OBS-1:0][CW-1:0]  x_q, x_d;
    logic [NUM_OBS-1:0][CW-1:0]  y_q, y_d;
    logic [NUM_OBS-1:0]          act_q, act_d;
    logic [SW-1:0]               score_q, score_d;
    logic [SW-1:0]               max_q, max_d;
    logic [2:0]                  step_q, step_d;
    logic [CW-1:0]               delay_q, delay_d;
    logic [CW-1:0]               timer_q, timer_d;
    logic [IW-1:0]               idx_q, idx_d;
    logic                        go_q, go_d;

    logic [CW-1:0]               cur_x, cur_y;
    logic                        cur_act;
    logic [NUM_OBS-1:0]          upd_oh;
    logic [NUM_OBS-1:0]          free_oh;
    logic                        free_any;
    logic [CW:0]                 y_nx;
    logic                        coll;
    logic                        hit;
    logic                        retire;
    logic [SW-1:0]               score_inc;
    logic [CW-1:0]               spawn_x;

    // Slot currently being advanced and the lowest free slot for spawning.
    always_comb begin
        cur_x    = '0;
        cur_y    = '0;
        cur_act  = 1'b0;
        upd_oh   = '0;
        free_oh  = '0;
        free_any = 1'b0;
        for (int unsigned i = 0; i < NUM_OBS; i++) begin
            if (IW'(i) == idx_q) begin
                upd_oh[i] = 1'b1;
                cur_x     = x_q[i];
                cur_y     = y_q[i];
                cur_act   = act_q[i];
            end
            if (!act_q[i] && !free_any) begin
                free_any   = 1'b1;
                free_oh[i] = 1'b1;
            end
        end
    end

    // Box overlap is evaluated in 12 bits so edge sums never wrap.
    assign y_nx = {1'b0, cur_y} + (CW+1)'(step_q);
    assign coll = (12'(cur_x) < 12'(bus.player_x) + 12'(PLAYER_W)) &&
                  (12'(bus.player_x) < 12'(cur_x) + 12'(OBS_SIZE)) &&
                  (12'(y_nx) < 12'(bus.player_y) + 12'(PLAYER_H)) &&
                  (12'(bus.player_y) < 12'(y_nx) + 12'(OBS_SIZE));
    assign hit       = cur_act && coll;
    assign retire    = cur_act && !coll && (y_nx >= (CW+1)'(SCREEN_H));
    assign score_inc = (score_q == '1) ? score_q : score_q + SW'(1);
    assign spawn_x   = (lfsr_q >= CW'(X_RANGE)) ? lfsr_q - CW'(X_RANGE) : lfsr_q;

    always_comb begin
        state_d = state_q;
        lfsr_d  = {lfsr_q[8:0], lfsr_q[9] ^ lfsr_q[6]};
        x_d     = x_q;
        y_d     = y_q;
        act_d   = act_q;
        score_d = score_q;
        max_d   = max_q;
        step_d  = step_q;
        delay_d = delay_q;
        timer_d = timer_q;
        idx_d   = idx_q;
        go_d    = go_q;

        case (state_q)
            S_IDLE, S_OVER: begin
                if (rise_q) begin
                    state_d = S_PLAY;
                    go_d    = 1'b0;
                    score_d = '0;
                    act_d   = '0;
                    x_d     = '0;
                    y_d     = '0;
                    timer_d = '0;
                    step_d  = 3'(STEP_INIT);
                    delay_d = CW'(SPAWN_DELAY_INIT);
                end
            end
            S_PLAY: begin
                if (bus.frame_tick) begin
                    state_d = S_UPDATE;
                    idx_d   = '0;
                    if (timer_q != '1) begin
                        timer_d = timer_q + CW'(1);
                    end
                end
            end
            S_UPDATE: begin
                for (int unsigned i = 0; i < NUM_OBS; i++) begin
                    if (upd_oh[i] && cur_act) begin
                        if (retire) begin
                            act_d[i] = 1'b0;
                            y_d[i]   = '0;
                        end else begin
                            y_d[i] = y_nx[CW-1:0];
                        end
                    end
                end
                // Difficulty steps up each time the score crosses a multiple of 8.
                if (retire) begin
                    score_d = score_inc;
                    if (score_inc > max_q) begin
                        max_d = score_inc;
                    end
                    if ((score_q != '1) && (score_inc[2:0] == 3'd0)) begin
                        delay_d = (delay_q >= CW'(SPAWN_DELAY_MIN + 4)) ?
                                  delay_q - CW'(4) : CW'(SPAWN_DELAY_MIN);
                        step_d  = (step_q == 3'd7) ? step_q : step_q + 3'd1;
                    end
                end
                if (hit) begin
                    state_d = S_OVER;
                    go_d    = 1'b1;
                end else if (idx_q == IW'(NUM_OBS - 1)) begin
                    state_d = S_SPAWN;
                end else begin
                    idx_d = idx_q + IW'(1);
                end
            end
            S_SPAWN: begin
                if ((timer_q >= delay_q) && free_any) begin
                    for (int unsigned i = 0; i < NUM_OBS; i++) begin
                        if (free_oh[i]) begin
                            act_d[i] = 1'b1;
                            y_d[i]   = '0;
                            x_d[i]   = spawn_x;
                        end
                    end
                    timer_d = '0;
                end
                state_d = S_PLAY;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            start_q <= 1'b0;
            rise_q  <= 1'b0;
            lfsr_q  <= LFSR_SEED;
            x_q     <= '0;
            y_q     <= '0;
            act_q   <= '0;
            score_q <= '0;
            max_q   <= '0;
            step_q  <= 3'(STEP_INIT);
            delay_q <= CW'(SPAWN_DELAY_INIT);
            timer_q <= '0;
            idx_q   <= '0;
            go_q    <= 1'b1;
        end else begin
            state_q <= state_d;
            start_q <= bus.start;
            rise_q  <= bus.start & ~start_q;
            lfsr_q  <= lfsr_d;
            x_q     <= x_d;
            y_q     <= y_d;
            act_q   <= act_d;
            score_q <= score_d;
            max_q   <= max_d;
            step_q  <= step_d;
            delay_q <= delay_d;
            timer_q <= timer_d;
            idx_q   <= idx_d;
            go_q    <= go_d;
        end
    end

    assign bus.obs_x      = x_q;
    assign bus.obs_y      = y_q;
    assign bus.obs_active = act_q;
    assign bus.game_over  = go_q;
    assign bus.score      = score_q;
    assign bus.max_score  = max_q;

endmodule

// File: doc/obstacle_scheduler.md
# obstacle_scheduler

Sequencing core of the VGA dodge game. It owns up to NUM_OBS falling obstacles, spawns them at pseudo-random x positions on a frame-counted timer, and advances them once per video frame. It also checks collisions against the player box and keeps score and max score. It runs the IDLE/PLAY/OVER game state machine. It sits between the player controller (supplies player position) and the sprite/pixel mixer (consumes obstacle positions and active flags).

## Interface
- NUM_OBS, 4: number of obstacle slots (1..8)
- SCREEN_H, 480: visible lines; obstacle retires when y ≥ SCREEN_H
- OBS_SIZE, 32: obstacle square side, pixels
- PLAYER_W, 32 / PLAYER_H, 32: player box size
- X_RANGE, 608: spawn x range, 0..X_RANGE-1 (SCREEN_W − OBS_SIZE)
- SPAWN_DELAY_INIT, 60: frames between spawns at game start
- SPAWN_DELAY_MIN, 16: delay floor
- STEP_INIT, 2: pixels per frame at game start (3-bit, max 7)
- LFSR_SEED, 10'h2A5: nonzero LFSR reset value

- CLOCK_50  in  1  system clock
- reset  in  1  asynchronous, active-high; clears all state
- frame_tick  in  1  one-cycle pulse per frame (vsync edge, generated upstream)
- start  in  1  level; rising edge starts a game
- player_x, player_y  in  10 each  player top-left corner
- obs_x  out  NUM_OBS*10  slot i at [10i+9:10i]
- obs_y  out  NUM_OBS*10  same packing
- obs_active  out  NUM_OBS  slot i visible
- game_over  out  1  high in IDLE and OVER
- score, max_score  out  7 each  saturating at 127

## Operation
- States: IDLE, PLAY, UPDATE, SPAWN, OVER.
- Reset: IDLE, game_over=1, score=0, max_score=0, obs_active=0, obs_x/obs_y=0, step=STEP_INIT, delay=SPAWN_DELAY_INIT, spawn_timer=0, slot index=0, LFSR=LFSR_SEED.
- start rise = start & ~start_q (start_q registered). In IDLE or OVER a rise clears score, all slots, spawn_timer, step and delay to initial values, keeps max_score, and enters PLAY with game_over=0.
- PLAY: frame_tick → UPDATE with index=0, spawn_timer+1 (saturating at 1023).
- UPDATE processes one slot per cycle, index 0..NUM_OBS-1. For an active slot:
  - y' = y + step, computed 11-bit.
  - Collision when ox < px+PLAYER_W, px < ox+OBS_SIZE, y' < py+PLAYER_H and py < y'+OBS_SIZE. On collision: y stored = y', state → OVER, game_over=1, remaining slots not updated, no score change.
  - Otherwise, if y' ≥ SCREEN_H: slot inactive, y=0, score+1 (sat), max_score=score if score exceeds it.
  - Otherwise y=y'.
  - Inactive slots are untouched.
  - After the last slot → SPAWN.
- SPAWN (one cycle), when spawn_timer ≥ delay:
  - Pick the lowest-index inactive slot; set active, y=0, x = lfsr ≥ X_RANGE ? lfsr − X_RANGE : lfsr; spawn_timer=0.
  - No free slot: nothing spawns, timer holds, retry next frame.
  - Then → PLAY.
- Difficulty: when the score increment makes score[2:0]==0, delay = max(delay−4, SPAWN_DELAY_MIN) and step = min(step+1, 7).
- LFSR: 10-bit Fibonacci, x^10+x^7+1, advances every clock in all states; never zero.
- frame_tick outside PLAY is ignored, including during UPDATE/SPAWN (no queuing).
- OVER: slots frozen and still displayed; only a start rise or reset leaves it.

## Timing
- All outputs registered.
- start rise sampled at edge N: game_over low and state PLAY after edge N+1.
- frame_tick at edge T: slot i updated at edge T+1+i; spawn at T+NUM_OBS+1; back in PLAY at T+NUM_OBS+2.
- Collision at slot i: game_over high after edge T+1+i.
- Score/max_score update in the same cycle as the retiring slot.
- reset asserted mid-frame: all state clears immediately, without waiting for a clock.

## Test plan
- Reset, then start rise: game_over 1→0 two edges after the rise; score=0, obs_active=0.
- PLAY, SPAWN_DELAY_INIT=2, player far away (x=600, y=0): first spawn after the 2nd frame_tick, slot0 active, y=0, x<608. Each later frame_tick gives y+2, with slot0 at T+1.
- Obstacle at y=478, step 2, no collision: next frame it retires (active=0), score=1, max_score=1. At score 8: delay 60→56, step 2→3.
- Player at (100,440), obstacle at x=100 reaching y=410: collision cycle gives game_over=1, state OVER, later frame_ticks leave positions unchanged. start rise then clears score and keeps max_score.
- All NUM_OBS slots active when timer expires: no spawn, spawn_timer holds ≥ delay. Spawn occurs the frame after a slot retires.
- reset pulse during UPDATE (between slots): all outputs return to reset values asynchronously. LFSR sequence restarts from 10'h2A5.
